svi_target: RTL and testbench
=============================

SVI_TARGET -- requirements
Module: svi_target

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 4, meaning request address width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning data width (multiple of 8).
REQ-003 The module SHALL have parameter NREGS, default 12, meaning implemented registers (1..2**ADDR_W).
REQ-004 Port clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port svi_req_valid  in  1  request valid from upstream SVI master.
REQ-007 Port svi_req_ready  out  1  request accepted when valid and ready are both high.
REQ-008 Port svi_req_write  in  1  1 = write, 0 = read.
REQ-009 Port svi_req_addr  in  ADDR_W  register index.
REQ-010 Port svi_req_wdata  in  DATA_W  write data.
REQ-011 Port svi_req_be  in  DATA_W/8  byte enables for writes.
REQ-012 Port svi_rsp_valid  out  1  response valid.
REQ-013 Port svi_rsp_ready  in  1  response consumed when valid and ready are both high.
REQ-014 Port svi_rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-015 Port svi_rsp_err  out  1  error flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: svi_req_ready=1; on handshake, capture write/addr/wdata/be and go to EXEC.
REQ-018 EXEC: svi_req_ready=0, one cycle; perform access; load response registers; go to RESP.
REQ-019 Write in EXEC: each register byte i SHALL update only where be[i]=1; rsp_rdata=0.
REQ-020 Read in EXEC: rsp_rdata SHALL be the register value before any same-cycle update.
REQ-021 RESP: svi_rsp_valid=1, svi_req_ready=0; rdata/err SHALL hold stable until handshake.
REQ-022 RESP and svi_rsp_ready=1: go to IDLE next cycle; no request is accepted in that handshake cycle.
REQ-023 Latency: request handshake at cycle N gives svi_rsp_valid=1 at N+2; minimum spacing between accepted requests is 3 cycles.
REQ-024 Address addr>=NREGS is out of range: write SHALL be dropped; read SHALL return 0.
REQ-025 be all-zero write SHALL complete normally with no register change.
REQ-026 svi_rsp_valid SHALL never deassert without a handshake (except reset).
REQ-027 The request inputs SHALL be ignored outside IDLE.

Reset
REQ-028 While rst=1: state=IDLE, all NREGS registers=0, svi_rsp_valid=0, svi_rsp_rdata=0, svi_rsp_err=0, svi_req_ready=0.
REQ-029 First cycle after rst falls: svi_req_ready=1.
REQ-030 Reset in EXEC or RESP SHALL drop the pending transaction and its response; a write already done in EXEC stays cleared by reset.

Configuration
REQ-031 Macro SVI_TARGET_ERR_EN defined: svi_rsp_err=1 in the response to any out-of-range access; in-range responses have err=0.
REQ-032 SVI_TARGET_ERR_EN undefined: svi_rsp_err SHALL be tied 0; out-of-range behaviour per REQ-024 unchanged.

Verification
REQ-033 Write addr=3 wdata=0xDEADBEEF be=0xF, then read addr=3 -> rdata=0xDEADBEEF, err=0, each response at N+2.
REQ-034 Write addr=3 wdata=0x11223344 be=0x5 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-035 Read addr=13 (NREGS=12) -> rdata=0; err=1 with SVI_TARGET_ERR_EN, err=0 without; a write to addr=13 leaves all registers unchanged.
REQ-036 Hold svi_rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err are stable; svi_req_ready=0 throughout; new requests are ignored.
REQ-037 Assert rst in RESP after writing addr=0 -> next cycle rsp_valid=0; after release a read of addr=0 returns 0.
REQ-038 Back-to-back valid with rsp_ready=1 -> requests accepted every 3rd cycle, in order, with no loss.

Source files
------------

// File: rtl/svi_target.sv
// svi_target: SVI register-file target with up to NREGS registers of DATA_W bits.
//
// Each request takes three states: IDLE accepts it, EXEC performs the access,
// RESP holds the response. An accepted request therefore produces svi_rsp_valid
// two cycles later. A new request can be accepted at most once every three cycles.
//
// Ports:
//   clk, rst        - clock (rising edge) and synchronous active-high reset
//   svi_req_*       - request channel (valid/ready, write, addr, wdata, byte enables)
//   svi_rsp_*       - response channel (valid/ready, rdata, err)
//
// Build option:
//   SVI_TARGET_ERR_EN - when defined, svi_rsp_err flags out-of-range accesses;
//                       otherwise svi_rsp_err is tied to 0.
module svi_target #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                svi_req_valid,
    output logic                svi_req_ready,
    input  logic                svi_req_write,
    input  logic [ADDR_W-1:0]   svi_req_addr,
    input  logic [DATA_W-1:0]   svi_req_wdata,
    input  logic [DATA_W/8-1:0] svi_req_be,
    output logic                svi_rsp_valid,
    input  logic                svi_rsp_ready,
    output logic [DATA_W-1:0]   svi_rsp_rdata,
    output logic                svi_rsp_err
);

    localparam int unsigned NBytes = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NBytes-1:0]   be_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   rd_val;

    // Out-of-range addresses match no register, so they read as 0 and
    // writes to them touch nothing.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rsp_rdata_d   = rsp_rdata_q;
        svi_req_ready = 1'b0;
        svi_rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                svi_req_ready = 1'b1;
                if (svi_req_valid) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                // rd_val comes from regs_q, i.e. the value before this cycle's write.
                rsp_rdata_d = write_q ? '0 : rd_val;
                state_d     = StResp;
            end
            StResp: begin
                svi_rsp_valid = 1'b1;
                if (svi_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Both handshake outputs stay low for as long as reset is asserted.
        if (rst) begin
            svi_req_ready = 1'b0;
            svi_rsp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rsp_rdata_q <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (state_q == StIdle && svi_req_valid) begin
                write_q <= svi_req_write;
                addr_q  <= svi_req_addr;
                wdata_q <= svi_req_wdata;
                be_q    <= svi_req_be;
            end
            if (state_q == StExec && write_q) begin
                for (int i = 0; i < int'(NREGS); i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        for (int b = 0; b < int'(NBytes); b++) begin
                            if (be_q[b]) begin
                                regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign svi_rsp_rdata = rsp_rdata_q;

`ifdef SVI_TARGET_ERR_EN
    localparam logic [ADDR_W:0] NRegsW = (ADDR_W + 1)'(NREGS);

    logic in_range;
    logic rsp_err_q;

    assign in_range = ({1'b0, addr_q} < NRegsW);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_err_q <= ~in_range;
        end
    end

    assign svi_rsp_err = rsp_err_q;
`else
    assign svi_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_svi_target.sv
// Directed bench for svi_target with a scoreboard of expected responses.
module tb_svi_target;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int NREGS  = 12;

`ifdef SVI_TARGET_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              svi_req_valid = 1'b0;
    logic              svi_req_ready;
    logic              svi_req_write = 1'b0;
    logic [ADDR_W-1:0] svi_req_addr = '0;
    logic [DATA_W-1:0] svi_req_wdata = '0;
    logic [3:0]        svi_req_be = '0;
    logic              svi_rsp_valid;
    logic              svi_rsp_ready = 1'b0;
    logic [DATA_W-1:0] svi_rsp_rdata;
    logic              svi_rsp_err;

    always #5 clk = ~clk;

    svi_target #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .svi_req_valid (svi_req_valid),
        .svi_req_ready (svi_req_ready),
        .svi_req_write (svi_req_write),
        .svi_req_addr  (svi_req_addr),
        .svi_req_wdata (svi_req_wdata),
        .svi_req_be    (svi_req_be),
        .svi_rsp_valid (svi_rsp_valid),
        .svi_rsp_ready (svi_rsp_ready),
        .svi_rsp_rdata (svi_rsp_rdata),
        .svi_rsp_err   (svi_rsp_err)
    );

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [3:0]        be;
    } req_t;

    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                n_rsp = 0;
    logic [DATA_W-1:0] model [NREGS];
    rsp_t              exp_q [$];
    int                lat_q [$];
    logic              prev_valid = 1'b0;
    logic              prev_rsp_hs = 1'b0;
    logic              prev_rst = 1'b1;
    logic [DATA_W-1:0] prev_rdata = '0;
    logic              prev_err = 1'b0;
    logic              req_hs_last = 1'b0;
    logic [DATA_W-1:0] last_rdata = '0;
    logic              last_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at edge+1 after inputs are driven; samples the cycle, then
    // advances to edge+1 of the next cycle.
    task automatic tick();
        rsp_t e;
        logic rsp_hs;
        logic req_hs;
        logic inr;
        #1;
        rsp_hs = 1'b0;
        req_hs = 1'b0;
        if (!rst) begin
            if (svi_rsp_valid) check("ready_low_in_resp", svi_req_ready, 0);
            if (prev_valid && !prev_rsp_hs && !prev_rst) begin
                check("valid_held", svi_rsp_valid, 1);
                check("rdata_stable", svi_rsp_rdata, prev_rdata);
                check("err_stable", svi_rsp_err, prev_err);
            end
            if (svi_rsp_valid && !prev_valid) begin
                if (lat_q.size() > 0) check("latency", cyc, lat_q[0] + 2);
                else check("spurious_rsp", svi_rsp_valid, 0);
            end
            rsp_hs = svi_rsp_valid && svi_rsp_ready;
            if (rsp_hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_hs, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (lat_q.size() > 0) void'(lat_q.pop_front());
                    check("rdata", svi_rsp_rdata, e.rdata);
                    check("err", svi_rsp_err, e.err);
                    last_rdata = svi_rsp_rdata;
                    last_err   = svi_rsp_err;
                    n_rsp++;
                end
            end
            req_hs = svi_req_valid && svi_req_ready;
            if (req_hs) begin
                inr = (int'(svi_req_addr) < NREGS);
                if (svi_req_write) begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (svi_req_be[b]) model[svi_req_addr][8*b +: 8] = svi_req_wdata[8*b +: 8];
                        end
                    end
                    e.rdata = '0;
                end else begin
                    e.rdata = inr ? model[svi_req_addr] : '0;
                end
                e.err = ErrEn & ~inr;
                exp_q.push_back(e);
                lat_q.push_back(cyc);
            end
        end
        prev_valid  = svi_rsp_valid;
        prev_rsp_hs = rsp_hs;
        prev_rst    = rst;
        prev_rdata  = svi_rsp_rdata;
        prev_err    = svi_rsp_err;
        req_hs_last = req_hs;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [3:0] be);
        svi_req_valid = 1'b1;
        svi_req_write = w;
        svi_req_addr  = a;
        svi_req_wdata = d;
        svi_req_be    = be;
    endtask

    task automatic wait_accept();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_hs_last) break;
        end
        check("req_timeout", req_hs_last, 1);
        svi_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) tick();
        check("rsp_timeout", exp_q.size(), 0);
    endtask

    task automatic run_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [3:0] be);
        drive(w, a, d, be);
        wait_accept();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t reqs [6];
        int   k;
        int   hs_prev;

        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", svi_req_ready, 0);
        check("rst_rsp_valid", svi_rsp_valid, 0);
        check("rst_rsp_rdata", svi_rsp_rdata, 0);
        check("rst_rsp_err", svi_rsp_err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", svi_req_ready, 1);
        svi_rsp_ready = 1'b1;

        // Full write then read back
        run_req(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        run_req(1'b0, 4'd3, 32'h0, 4'h0);
        check("rd3_full", last_rdata, 32'hDEADBEEF);
        check("rd3_err", last_err, 0);

        // Partial byte-enable write
        run_req(1'b1, 4'd3, 32'h11223344, 4'h5);
        run_req(1'b0, 4'd3, 32'h0, 4'h0);
        check("rd3_partial", last_rdata, 32'hDE22BE44);

        // be all-zero write changes nothing
        run_req(1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
        run_req(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
        run_req(1'b0, 4'd5, 32'h0, 4'h0);
        check("be_zero", last_rdata, 32'hCAFEF00D);

        // Top in-range register
        run_req(1'b1, 4'd11, 32'h5A5AA5A5, 4'hA);
        run_req(1'b0, 4'd11, 32'h0, 4'h0);
        check("rd11", last_rdata, 32'h5A00A500);

        // Out-of-range accesses
        run_req(1'b0, 4'd13, 32'h0, 4'h0);
        check("oor_rdata", last_rdata, 0);
        check("oor_err", last_err, ErrEn);
        run_req(1'b1, 4'd13, 32'hA5A5A5A5, 4'hF);
        run_req(1'b1, 4'd12, 32'h12121212, 4'hF);
        run_req(1'b0, 4'd15, 32'h0, 4'h0);
        check("oor15_rdata", last_rdata, 0);
        for (int i = 0; i < NREGS; i++) run_req(1'b0, ADDR_W'(i), 32'h0, 4'h0);

        // Response stall: outputs hold and new requests are ignored
        run_req(1'b1, 4'd7, 32'h0BADC0DE, 4'hF);
        svi_rsp_ready = 1'b0;
        drive(1'b0, 4'd7, 32'h0, 4'h0);
        wait_accept();
        drive(1'b1, 4'd7, 32'h0, 4'hF);
        repeat (6) tick();
        check("stall_valid", svi_rsp_valid, 1);
        check("stall_req_ready", svi_req_ready, 0);
        svi_req_valid = 1'b0;
        svi_rsp_ready = 1'b1;
        drain();
        check("stall_rdata", last_rdata, 32'h0BADC0DE);
        run_req(1'b0, 4'd7, 32'h0, 4'h0);
        check("stall_write_ignored", last_rdata, 32'h0BADC0DE);

        // Reset while a write response is pending
        svi_rsp_ready = 1'b0;
        drive(1'b1, 4'd0, 32'h12345678, 4'hF);
        wait_accept();
        for (int j = 0; j < 10 && !svi_rsp_valid; j++) tick();
        check("pre_rst_valid", svi_rsp_valid, 1);
        rst = 1'b1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        exp_q.delete();
        lat_q.delete();
        tick();
        check("rst_drops_valid", svi_rsp_valid, 0);
        rst = 1'b0;
        #1;
        check("post_rst_valid", svi_rsp_valid, 0);
        check("post_rst_ready", svi_req_ready, 1);
        svi_rsp_ready = 1'b1;
        run_req(1'b0, 4'd0, 32'h0, 4'h0);
        check("rd0_after_rst", last_rdata, 0);
        run_req(1'b0, 4'd3, 32'h0, 4'h0);
        check("rd3_after_rst", last_rdata, 0);

        // Back-to-back requests with valid held high
        reqs[0] = '{1'b1, 4'd1, 32'h11110001, 4'hF};
        reqs[1] = '{1'b0, 4'd1, 32'h0, 4'h0};
        reqs[2] = '{1'b1, 4'd2, 32'h22220002, 4'h3};
        reqs[3] = '{1'b0, 4'd2, 32'h0, 4'h0};
        reqs[4] = '{1'b1, 4'd1, 32'hFF00FF00, 4'hC};
        reqs[5] = '{1'b0, 4'd1, 32'h0, 4'h0};
        k = 0;
        hs_prev = 0;
        n_rsp = 0;
        drive(reqs[0].w, reqs[0].a, reqs[0].d, reqs[0].be);
        for (int t = 0; t < 60 && (k < 6 || exp_q.size() > 0); t++) begin
            tick();
            if (req_hs_last) begin
                if (k > 0) check("b2b_spacing", (cyc - 1) - hs_prev, 3);
                hs_prev = cyc - 1;
                k++;
                if (k < 6) drive(reqs[k].w, reqs[k].a, reqs[k].d, reqs[k].be);
                else svi_req_valid = 1'b0;
            end
        end
        check("b2b_accepted", k, 6);
        check("b2b_responses", n_rsp, 6);
        check("b2b_last_rdata", last_rdata, 32'hFF000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
